mul_operand_capture: RTL

- Upstream conditioning stage for the multiplier-operand PIO input port.
- Captures a DATA_W-bit operand from an external, asynchronous producer over a 4-phase req/ack handshake.
- Holds the operand stable on data_out, which drives the PIO in_port.
- Provides sample counter and fresh/overrun status for software-visible or interrupt use.

---
 rtl/mul_operand_capture.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mul_operand_capture.sv
// mul_operand_capture: 4-phase req/ack operand capture feeding the multiplier PIO in_port; optional
// req qualification compiled in with MUL_CAPTURE_DEBOUNCE_EN
module mul_operand_capture #(
    parameter int DATA_W          = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] ext_data,
    input  logic              ext_req,
    output logic              ext_ack,
    output logic [DATA_W-1:0] data_out,
    output logic [7:0]        sample_count,
    output logic              fresh,
    output logic              overrun,
    input  logic              data_consume,
    input  logic              clear_overrun,
    output logic              busy
);
    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("mul_operand_capture: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

`ifdef MUL_CAPTURE_DEBOUNCE_EN
    typedef enum logic [1:0] {IDLE, QUAL, CAPTURE, ACK} state_t;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`else
    typedef enum logic [1:0] {IDLE, CAPTURE, ACK} state_t;
`endif

    state_t            state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [7:0]        count_q, count_d;
    logic              ack_q, ack_d;
    logic              fresh_q, fresh_d;
    logic              overrun_q, overrun_d;
    logic              busy_q, busy_d;
    logic              req_s;
    logic              capture;

    assign req_s        = sync_q[SYNC_STAGES-1];
    assign capture      = (state_q == CAPTURE);
    assign ext_ack      = ack_q;
    assign data_out     = data_q;
    assign sample_count = count_q;
    assign fresh        = fresh_q;
    assign overrun      = overrun_q;
    assign busy         = busy_q;

    // handshake FSM next state plus the capture-edge updates of operand, counter and status flags
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], ext_req};
        state_d   = state_q;
        data_d    = data_q;
        count_d   = count_q;
        ack_d     = ack_q;
`ifdef MUL_CAPTURE_DEBOUNCE_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_s) begin
`ifdef MUL_CAPTURE_DEBOUNCE_EN
                    state_d = QUAL;
                    cnt_d   = CW'(1);
`else
                    state_d = CAPTURE;
`endif
                end
            end
`ifdef MUL_CAPTURE_DEBOUNCE_EN
            QUAL: begin
                if (!req_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            CAPTURE: begin
                data_d  = ext_data;
                count_d = count_q + 8'd1;
                ack_d   = 1'b1;
                state_d = ACK;
            end
            ACK: begin
                if (!req_s) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        fresh_d   = capture ? 1'b1 : (data_consume ? 1'b0 : fresh_q);
        overrun_d = (capture && fresh_q && !data_consume) ? 1'b1 : (clear_overrun ? 1'b0 : overrun_q);
        busy_d    = (state_d != IDLE);
    end

    // state registers, all cleared asynchronously by reset_n
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '0;
            state_q   <= IDLE;
            data_q    <= '0;
            count_q   <= '0;
            ack_q     <= 1'b0;
            fresh_q   <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef MUL_CAPTURE_DEBOUNCE_EN
            cnt_q     <= '0;
`endif
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            data_q    <= data_d;
            count_q   <= count_d;
            ack_q     <= ack_d;
            fresh_q   <= fresh_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
`ifdef MUL_CAPTURE_DEBOUNCE_EN
            cnt_q     <= cnt_d;
`endif
        end
    end
endmodule
